terminal_out_fifo: RTL and testbench
====================================

Name: terminal_out_fifo

Overview:
- Downstream consumer of the register file's OUT path. Each OUT instruction presents a byte of outTerminal data, and this block buffers it in a small FIFO.
- Drains the buffered bytes to the external terminal/display over a valid/ready handshake, so the single-cycle core never waits on a slow terminal.
- Reports full/empty/count and a sticky overflow flag to the control unit and debug LEDs.

Parameters:
- DEPTH, 8, number of byte entries; must be a power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock (processor clock after divider); all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- wr_en  input  1  asserted for the cycle an OUT instruction executes (REGOP == 3'b110); level-sampled on each posedge.
- wr_data  input  8  byte to enqueue (register value selected by regAddr1).
- clr_ovf  input  1  clears the sticky overflow flag.
- term_data  output  8  head-of-queue byte.
- term_valid  output  1  head byte is valid.
- term_ready  input  1  terminal accepts term_data at this posedge.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky: a write was dropped.

Behaviour:
- Reset: on a posedge with rst=1:
  - wr_ptr, rd_ptr and count go to 0; overflow goes to 0.
  - term_valid=0, empty=1, full=0; term_data reads 0.
  - Memory contents are don't-care.
  - rst overrides all other inputs, including a write or handshake in the same cycle. Reset mid-drain discards all queued bytes.
- Storage: DEPTH x 8 register array written on posedge; wr_ptr and rd_ptr are ADDR_W bits and wrap DEPTH-1 -> 0 naturally.
- Show-ahead read: term_data = mem[rd_ptr] combinationally; term_valid = !empty.
  - When empty, term_data is held at 0 (masked) so the terminal never latches stale data.
- Latency: a byte written at posedge N (queue previously empty) gives term_valid=1 and term_data=byte during cycle N+1. A same-cycle write-to-read bypass is not provided.
- Pop: a pop occurs at a posedge where term_valid && term_ready; rd_ptr increments. If term_valid=0, term_ready is ignored.
- Push: a push occurs at a posedge where wr_en && (!full || pop); mem[wr_ptr] <= wr_data and wr_ptr increments.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, a pop in the same cycle frees the slot and the write is accepted.
  - When empty, no pop is possible; only the push happens.
- Count update: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- Overflow: wr_en && full && !pop -> the write is dropped (no pointer or memory change) and overflow <= 1.
  - overflow stays 1 until clr_ovf or rst.
  - If clr_ovf and a new drop occur in the same cycle, the set wins (overflow stays 1).
- full, empty and count are derived from registered count, so they are glitch-free and valid the cycle after the causing edge.
- Exactly one enqueue per cycle with wr_en high. A multi-cycle wr_en enqueues one byte per cycle; no edge detection is done.
- All outputs are X-free after reset regardless of the memory's initial contents.

Test Plan:
- Reset then idle:
  - Apply rst for 2 cycles with wr_en=1 and wr_data=8'hAA.
  - Required: count=0, empty=1, term_valid=0, term_data=0, overflow=0.
  - After releasing rst: no entries exist (the writes during reset were ignored).
- Single byte latency:
  - Set term_ready=0 and pulse wr_en one cycle with 8'h5A.
  - Required: the next cycle shows term_valid=1, term_data=8'h5A, count=1.
  - Raise term_ready for one cycle -> empty=1, term_valid=0.
- Fill, overflow and order:
  - With term_ready=0, write 8'h01..8'h09 (9 writes).
  - Required: full=1 and count=8 after the 8th write; overflow=1 after the 9th.
  - Draining gives 01..08 in order, with no 09.
  - Pulse clr_ovf -> overflow=0.
- Full with simultaneous push/pop:
  - Fill with 10..17, then assert wr_en(8'h20) and term_ready in the same cycle.
  - Required: 10 is popped, 20 is accepted, count stays 8, overflow stays 0.
  - Drain order is 11..17, 20.
- Pointer wrap streaming:
  - Hold term_ready=1 and write 20 consecutive bytes 0..19.
  - Required: each byte appears on term_data one cycle after its write; count never exceeds 1; no overflow.
- Reset mid-drain:
  - With 5 bytes queued and term_ready toggling, assert rst for one cycle.
  - Required: empty=1 next cycle.
  - A subsequent write of 8'h77 appears as the sole valid byte.

Source files
------------

// File: rtl/terminal_out_fifo.sv
// rtl/terminal_out_fifo.sv - show-ahead byte FIFO draining OUT-instruction data to the terminal
module terminal_out_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  output logic [7:0]        term_data,
  output logic              term_valid,
  input  logic              term_ready,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              ovf_q,    ovf_d;

  logic pop;
  logic push;
  logic drop;

  // Status flags come straight from the registered count so they never glitch.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == DEPTH_C);
    count      = count_q;
    overflow   = ovf_q;
    term_valid = !empty;
    // Mask the head byte when empty so the terminal never sees stale memory.
    term_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  end

  // Handshake decode and next-state for pointers, count and the sticky overflow flag.
  always_comb begin
    pop      = term_valid && term_ready;
    // A pop in the same cycle frees a slot, so a full queue still accepts the write.
    push     = wr_en && (!full || pop);
    drop     = wr_en && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // A fresh drop beats a clear issued in the same cycle.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Control state register; reset overrides any write or handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage; contents need no reset because reads are masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_terminal_out_fifo.sv
// tb/tb_terminal_out_fifo.sv - randomized and directed check of terminal_out_fifo against a queue model
module tb_terminal_out_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            clr_ovf = 1'b0;
  logic [7:0]      term_data;
  logic            term_valid;
  logic            term_ready = 1'b0;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  int         max_cnt;

  terminal_out_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clr_ovf    (clr_ovf),
    .term_data  (term_data),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(mq.size()));
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("term_valid", 32'(term_valid), 32'(mq.size() != 0));
    check("term_data", 32'(term_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model by the queue rules, then compare.
  task automatic cyc(input logic r, input logic w, input logic [7:0] d,
                     input logic rd, input logic c);
    bit do_pop;
    bit was_full;
    rst = r; wr_en = w; wr_data = d; term_ready = rd; clr_ovf = c;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      do_pop   = (mq.size() != 0) && rd;
      was_full = (mq.size() == DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (w && (!was_full || do_pop)) mq.push_back(d);
      if (w && was_full && !do_pop) m_ovf = 1'b1;
      else if (c)                   m_ovf = 1'b0;
    end
    #1;
    check_all();
    if (mq.size() > max_cnt) max_cnt = mq.size();
  endtask

  initial begin
    // Reset with a write pending: the writes must be ignored.
    cyc(1, 1, 8'hAA, 0, 0);
    cyc(1, 1, 8'hAA, 0, 0);
    check("rst_term_data", 32'(term_data), 32'h0);
    cyc(0, 0, 8'h00, 0, 0);
    check("rst_no_entries", 32'(count), 32'h0);

    // Single byte latency and pop.
    cyc(0, 1, 8'h5A, 0, 0);
    check("lat_data", 32'(term_data), 32'h5A);
    check("lat_valid", 32'(term_valid), 32'h1);
    cyc(0, 0, 8'h00, 1, 0);
    check("pop_empty", 32'(empty), 32'h1);

    // Fill, overflow, order, clear.
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 1, 8'(i), 0, 0);
      if (i == 8) check("fill_full", 32'(full), 32'h1);
    end
    check("ovf_set", 32'(overflow), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 32'(term_data), 32'(i));
      cyc(0, 0, 8'h00, 1, 0);
    end
    check("drain_empty", 32'(empty), 32'h1);
    cyc(0, 0, 8'h00, 0, 1);
    check("ovf_clr", 32'(overflow), 32'h0);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'h10 + i), 0, 0);
    cyc(0, 1, 8'h20, 1, 0);
    check("pp_count", 32'(count), 32'h8);
    check("pp_ovf", 32'(overflow), 32'h0);
    check("pp_head", 32'(term_data), 32'h11);
    while (mq.size() != 0) cyc(0, 0, 8'h00, 1, 0);

    // Streaming through the pointer wrap.
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 8'(i), 1, 0);
      check("stream_data", 32'(term_data), 32'(i));
    end
    check("stream_max_cnt", 32'(max_cnt), 32'h1);
    cyc(0, 0, 8'h00, 1, 0);

    // Reset mid-drain.
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'($urandom), 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(1, 0, 8'h00, 1, 0);
    check("mid_rst_empty", 32'(empty), 32'h1);
    cyc(0, 1, 8'h77, 0, 0);
    check("post_rst_data", 32'(term_data), 32'h77);
    check("post_rst_count", 32'(count), 32'h1);
    cyc(0, 0, 8'h00, 1, 0);

    // Randomized traffic including occasional clears and resets.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(9) < 6), 8'($urandom),
          ($urandom_range(9) < 4 + (n / 200)), ($urandom_range(9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
